// File: rtl/sample_test_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sample_test_multi : two-stage multi-sample edge-function coverage test (R16->R18)
// Rev 1.0
// ----------------------------------------------------------------------------
module sample_test_multi #(
    parameter int SIGFIG  = 24,
    parameter int RADIX   = 10,
    parameter int VERTS   = 3,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    input  logic [COLORS-1:0][SIGFIG-1:0]                 color_R16U,
    input  logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0]    sample_R16S,
    input  logic [SAMPLES-1:0]                            validSamp_R16H,
    output logic signed [SAMPLES-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S,
    output logic [COLORS-1:0][SIGFIG-1:0]                 color_R18U,
    output logic [SAMPLES-1:0]                            hit_valid_R18H,
    output logic [31:0]                                   hit_count_RnnnnU
);

    localparam int VW = SIGFIG + 1;
    localparam int PW = 2 * SIGFIG + 2;
    localparam int DW = PW + 1;
    localparam int CW = $clog2(SAMPLES + 1);

    if (VERTS != 3 || RADIX >= SIGFIG) begin : g_param_check
        $error("sample_test_multi: unsupported VERTS/RADIX combination");
    end

    function automatic logic signed [VW-1:0] sext(input logic [SIGFIG-1:0] a);
        return $signed({a[SIGFIG-1], a});
    endfunction

    // a.x*b.y - b.x*a.y at full precision; one extra bit absorbs the subtraction
    function automatic logic signed [DW-1:0] edge_fn(
        input logic signed [VW-1:0] ax,
        input logic signed [VW-1:0] ay,
        input logic signed [VW-1:0] bx,
        input logic signed [VW-1:0] by
    );
        logic signed [PW-1:0] p_ab;
        logic signed [PW-1:0] p_ba;
        p_ab = PW'(ax) * PW'(by);
        p_ba = PW'(bx) * PW'(ay);
        return DW'(p_ab) - DW'(p_ba);
    endfunction

    // Only vertex 0 carries the flat depth
    logic w_unused;
    assign w_unused = ^{tri_R16S[1][2], tri_R16S[2][2]};

    logic signed [VW-1:0] w_vx [SAMPLES][VERTS];
    logic signed [VW-1:0] w_vy [SAMPLES][VERTS];

    always_comb begin
        for (int s = 0; s < SAMPLES; s++) begin
            for (int j = 0; j < VERTS; j++) begin
                w_vx[s][j] = sext(tri_R16S[j][0]) - sext(sample_R16S[s][0]);
                w_vy[s][j] = sext(tri_R16S[j][1]) - sext(sample_R16S[s][1]);
            end
        end
    end

    logic signed [VW-1:0]                r_vx [SAMPLES][VERTS];
    logic signed [VW-1:0]                r_vy [SAMPLES][VERTS];
    logic [SAMPLES-1:0][1:0][SIGFIG-1:0] r_samp17;
    logic [SAMPLES-1:0]                  r_valid17;
    logic [SIGFIG-1:0]                   r_z17;
    logic [COLORS-1:0][SIGFIG-1:0]       r_color17;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SAMPLES; s++) begin
                for (int j = 0; j < VERTS; j++) begin
                    r_vx[s][j] <= '0;
                    r_vy[s][j] <= '0;
                end
            end
            r_samp17  <= '0;
            r_valid17 <= '0;
            r_z17     <= '0;
            r_color17 <= '0;
        end else begin
            for (int s = 0; s < SAMPLES; s++) begin
                for (int j = 0; j < VERTS; j++) begin
                    r_vx[s][j] <= w_vx[s][j];
                    r_vy[s][j] <= w_vy[s][j];
                end
            end
            r_samp17  <= sample_R16S;
            r_valid17 <= validSamp_R16H;
            r_z17     <= tri_R16S[0][2];
            r_color17 <= color_R16U;
        end
    end

    logic signed [DW-1:0] w_d0 [SAMPLES];
    logic signed [DW-1:0] w_d1 [SAMPLES];
    logic signed [DW-1:0] w_d2 [SAMPLES];
    logic [SAMPLES-1:0]   w_hit;
    logic [CW-1:0]        w_pop;
    logic [32:0]          w_cnt_sum;
    logic [31:0]          r_hit_count;

    // Tie rule: on edge0/edge2 counts as inside, on edge1 as outside
    always_comb begin
        w_hit = '0;
        w_pop = '0;
        for (int s = 0; s < SAMPLES; s++) begin
            w_d0[s] = edge_fn(r_vx[s][0], r_vy[s][0], r_vx[s][1], r_vy[s][1]);
            w_d1[s] = edge_fn(r_vx[s][1], r_vy[s][1], r_vx[s][2], r_vy[s][2]);
            w_d2[s] = edge_fn(r_vx[s][2], r_vy[s][2], r_vx[s][0], r_vy[s][0]);
            w_hit[s] = r_valid17[s]
                     & (w_d0[s][DW-1] | (w_d0[s] == '0))
                     & w_d1[s][DW-1]
                     & (w_d2[s][DW-1] | (w_d2[s] == '0));
            w_pop = w_pop + CW'(w_hit[s]);
        end
        w_cnt_sum = {1'b0, r_hit_count} + 33'(w_pop);
    end

    logic [SAMPLES-1:0][AXIS-1:0][SIGFIG-1:0] r_hit18;
    logic [COLORS-1:0][SIGFIG-1:0]            r_color18;
    logic [SAMPLES-1:0]                       r_hit_valid18;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit18       <= '0;
            r_color18     <= '0;
            r_hit_valid18 <= '0;
            r_hit_count   <= '0;
        end else begin
            for (int s = 0; s < SAMPLES; s++) begin
                r_hit18[s][0] <= r_samp17[s][0];
                r_hit18[s][1] <= r_samp17[s][1];
                r_hit18[s][2] <= r_z17;
            end
            r_color18     <= r_color17;
            r_hit_valid18 <= w_hit;
            r_hit_count   <= w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
        end
    end

    assign hit_R18S         = r_hit18;
    assign color_R18U       = r_color18;
    assign hit_valid_R18H   = r_hit_valid18;
    assign hit_count_RnnnnU = r_hit_count;

endmodule
`default_nettype wire

// File: doc/sample_test_multi.md
Name: sample_test_multi

Overview:
Pipelined multi-sample coverage test sitting directly upstream of the z-buffer model. Each cycle it takes one triangle and SAMPLES candidate sample positions. It evaluates three edge functions per sample, and two cycles later drives per-sample hit position/depth, triangle colour and hit valids in the R18 format the z-buffer consumes. Synthesizable; no stall path, because the z-buffer accepts one beat every cycle.

Parameters:
SIGFIG, 24, bits in position/colour words
RADIX, 10, fraction bits in position words
VERTS, 3, vertices per triangle (block supports exactly 3)
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, colour channels
SAMPLES, 2, samples tested per cycle

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
tri_R16S  input  signed [SIGFIG-1:0] [VERTS-1:0][AXIS-1:0]  triangle vertices, clockwise, fixed point
color_R16U  input  unsigned [SIGFIG-1:0] [COLORS-1:0]  flat triangle colour
sample_R16S  input  signed [SIGFIG-1:0] [SAMPLES-1:0][1:0]  sample x,y
validSamp_R16H  input  1 [SAMPLES-1:0]  sample i is valid this cycle
hit_R18S  output  signed [SIGFIG-1:0] [SAMPLES-1:0][AXIS-1:0]  hit x,y (= sample), z (= vertex0 z)
color_R18U  output  unsigned [SIGFIG-1:0] [COLORS-1:0]  colour of the beat
hit_valid_R18H  output  1 [SAMPLES-1:0]  sample i hit
hit_count_RnnnnU  output  32  saturating count of asserted hit valids since reset

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-low. While rst=0, all R17/R18 registers are 0: hit_R18S=0, color_R18U=0, hit_valid_R18H=0, hit_count_RnnnnU=0. This includes the stage-valid registers. Deassertion takes effect on the next posedge.
- Reset mid-stream drops any beats in flight. No hit is emitted for an R16 beat presented within 2 cycles before reset is asserted.
- Latency: fixed 2 cycles, R16 -> R17 -> R18. Throughput is 1 beat/cycle. Every register advances every cycle.
- Stage R16->R17, per sample i:
  - Shifted vertex vj' = vj.xy - sample_i.xy, computed SIGFIG+1 bits wide with no overflow.
  - Register vj', sample_i, validSamp_i, tri[0][2] and colour.
- Stage R17->R18, per sample i:
  - d0 = v0x'*v1y' - v1x'*v0y'
  - d1 = v1x'*v2y' - v2x'*v1y'
  - d2 = v2x'*v0y' - v0x'*v2y'
  - Products are full width, 2*SIGFIG+2 bits signed. There is no truncation before the compare.
  - hit_i = valid_i & (d0<=0) & (d1<0) & (d2<=0). This is the top-left style tie rule: a sample on edge0 or edge2 is inside, a sample on edge1 is outside.
- R18 outputs, per sample:
  - hit_R18S[i][0..1] = registered sample x,y.
  - hit_R18S[i][2] = registered tri[0][2]; flat depth, the same for all samples.
  - color_R18U = registered colour, shared by all samples of the beat.
- Outputs with hit_valid_R18H[i]=0: position/colour still update every cycle (don't-care to the consumer). hit_valid is the only qualifier.
- Degenerate triangle (zero area): all d are 0, so d1<0 fails and there is no hit.
- Counter: each cycle, add popcount(next hit_valid_R18H), i.e. the hits entering R18 that cycle. hit_count_RnnnnU then equals the total asserted hit valids once they are visible. It saturates at 0xFFFFFFFF and holds; no wrap.
- Invalid samples (validSamp=0) never produce a hit, whatever their geometry.

Test Plan:
1. Reset: hold rst=0 with random inputs -> all outputs 0. Release; present nothing valid -> hit_valid_R18H stays 0 and count stays 0.
2. Interior hit, latency check:
   - Stimulus: tri v0=(0,0,z=0x100), v1=(0,4096), v2=(4096,0) (pixels x1024); sample0=(1024,1024), sample1=(5120,5120), both valid at cycle N.
   - Response at N+2: hit_valid=2'b01, hit_R18S[0]=(1024,1024,0x100), colour echoed, count=1.
3. Tie rule, same triangle:
   - sample0=(0,2048) on edge0 -> hit.
   - sample1=(2048,2048) on edge1 -> no hit (d1=0).
4. Back-to-back streaming: 8 consecutive beats alternating two triangles and colours -> R18 outputs match each beat exactly 2 cycles later, with no bubbles and no colour mixing.
5. Invalid and reset mid-stream:
   - validSamp=2'b10 with both samples inside -> only bit1 hits.
   - Pulse rst low for 1 cycle with 2 beats in flight -> neither beat emerges; count is 0.
6. Saturation: force the count near 0xFFFFFFFE, then drive two all-hit beats -> count reads 0xFFFFFFFF and holds.
